imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch.sv | 93 +++++++++
 tb/tb_imem_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction fetch unit: walks a 64-word instruction memory and buffers
// fetched words with their byte addresses in a two-entry queue.
module imem_fetch #(
    parameter int N     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic [5:0]   imem_addr,
    input  logic [31:0]  imem_q,
    input  logic         branch_i,
    input  logic [N-1:0] branch_target_i,
    output logic [31:0]  instr_o,
    output logic [N-1:0] pc_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         halt_o
);

    localparam logic [31:0] HALT_WORD = 32'hb400001f;
    localparam logic [1:0]  FULL      = 2'(DEPTH);

    logic [N-1:0] pc;
    logic [1:0]   count;
    logic         halt;
    logic [31:0]  q_instr [2];
    logic [N-1:0] q_pc    [2];

    logic         head;
    logic         pop;
    logic         push;

    // Outputs are forced to zero while reset is held, even mid-operation.
    assign head      = (count != 2'd0) && !reset;
    assign imem_addr = reset ? 6'd0 : pc[7:2];
    assign valid_o   = head && !branch_i;
    assign instr_o   = head ? q_instr[0] : 32'd0;
    assign pc_o      = head ? q_pc[0] : '0;
    assign halt_o    = halt && !reset;

    assign pop  = valid_o && ready_i;
    assign push = ((count < FULL) || pop) && !halt && !branch_i && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            count <= 2'd0;
            halt  <= 1'b0;
        end else if (branch_i) begin
            pc    <= branch_target_i & ~N'(3);
            count <= 2'd0;
            halt  <= 1'b0;
        end else begin
            if (push) begin
                pc <= pc + N'(4);
                if (imem_q == HALT_WORD)
                    halt <= 1'b1;
            end
            unique case ({push, pop})
                2'b10: count <= count + 2'd1;
                2'b01: count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        unique case ({push, pop})
            2'b10: begin
                q_instr[count[0]] <= imem_q;
                q_pc[count[0]]    <= pc;
            end
            2'b01: begin
                q_instr[0] <= q_instr[1];
                q_pc[0]    <= q_pc[1];
            end
            2'b11: begin
                if (count == 2'd2) begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                    q_instr[1] <= imem_q;
                    q_pc[1]    <= pc;
                end else begin
                    q_instr[0] <= imem_q;
                    q_pc[0]    <= pc;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed plus randomized bench for imem_fetch against a queue-based model.
module tb_imem_fetch;

    localparam int N = 64;
    localparam logic [31:0] HALT_WORD = 32'hb400001f;

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   imem_addr;
    logic [31:0]  imem_q;
    logic         branch_i;
    logic [N-1:0] branch_target_i;
    logic [31:0]  instr_o;
    logic [N-1:0] pc_o;
    logic         valid_o;
    logic         ready_i;
    logic         halt_o;

    logic [31:0] rom [64];
    assign imem_q = rom[imem_addr];

    imem_fetch #(.N(N), .DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_q          (imem_q),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .halt_o          (halt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  instr;
        logic [N-1:0] pc;
    } entry_t;

    entry_t       mq[$];
    logic [N-1:0] m_pc;
    bit           m_halt;
    int           vectors = 0;
    int           errors  = 0;

    task automatic check(input string tag, input logic [N-1:0] obs,
                         input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic         e_valid;
        logic [31:0]  e_instr;
        logic [N-1:0] e_pc;
        logic [5:0]   e_addr;
        logic         e_halt;
        if (reset) begin
            e_valid = 0; e_instr = 0; e_pc = 0; e_addr = 0; e_halt = 0;
        end else begin
            e_valid = (mq.size() > 0) && !branch_i;
            e_instr = (mq.size() > 0) ? mq[0].instr : 32'd0;
            e_pc    = (mq.size() > 0) ? mq[0].pc : '0;
            e_addr  = 6'((m_pc % 256) / 4);
            e_halt  = m_halt;
        end
        check("valid_o", N'(valid_o), N'(e_valid));
        check("instr_o", N'(instr_o), N'(e_instr));
        check("pc_o", pc_o, e_pc);
        check("imem_addr", N'(imem_addr), N'(e_addr));
        check("halt_o", N'(halt_o), N'(e_halt));
    endtask

    task automatic model_step();
        bit     do_pop;
        bit     do_push;
        entry_t e;
        if (reset) begin
            mq.delete();
            m_pc = 0;
            m_halt = 0;
        end else if (branch_i) begin
            mq.delete();
            m_pc = branch_target_i - (branch_target_i % 4);
            m_halt = 0;
        end else begin
            do_pop  = (mq.size() > 0) && ready_i;
            do_push = (mq.size() < 2 || do_pop) && !m_halt;
            if (do_push) begin
                e.instr = rom[(m_pc % 256) / 4];
                e.pc    = m_pc;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(e);
                m_pc = m_pc + 4;
                if (e.instr == HALT_WORD) m_halt = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic b,
                        input logic [N-1:0] tgt, input logic rdy);
        @(negedge clk);
        reset = r;
        branch_i = b;
        branch_target_i = tgt;
        ready_i = rdy;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom[k] = 32'h8b000000 + k;
        reset = 1'b1;
        branch_i = 1'b0;
        branch_target_i = '0;
        ready_i = 1'b0;
        m_pc = 0;
        m_halt = 0;

        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        run(20, 1'b1);
        run(5, 1'b0);
        run(6, 1'b1);
        run(3, 1'b0);
        step(1'b0, 1'b1, 64'h43, 1'b1);
        run(4, 1'b1);
        step(1'b0, 1'b1, 64'hf0, 1'b1);
        run(10, 1'b1);
        run(3, 1'b0);

        rom[3] = HALT_WORD;
        step(1'b0, 1'b1, 64'h0, 1'b0);
        run(3, 1'b0);
        run(10, 1'b1);
        step(1'b0, 1'b1, 64'h0, 1'b1);
        rom[3] = 32'h8b000003;
        run(3, 1'b1);

        run(3, 1'b0);
        step(1'b1, 1'b1, 64'h80, 1'b1);
        run(6, 1'b1);

        rom[17] = HALT_WORD;
        rom[45] = HALT_WORD;
        for (int i = 0; i < 2000; i++) begin
            logic         r;
            logic         b;
            logic [N-1:0] t;
            r = ($urandom_range(0, 63) == 0);
            b = ($urandom_range(0, 15) == 0);
            t = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) t = t % 512;
            step(r, b, t, 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
